// File: rtl/simd_stream_alu_if.sv
`default_nettype none
// ============================================================================
// Module  : simd_stream_alu_if
// Purpose : Load/command/result bundle between the byte loader, the SIMD
//           stream ALU and the narrow return bus.
// Rev     : 1.0  initial release
// ============================================================================
interface simd_stream_alu_if #(
    parameter int DW = 8,
    parameter int OW = 4
);
    logic          load;
    logic [DW-1:0] din;
    logic [3:0]    mode;
    logic          dtype;
    logic          send;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          loaded;
    logic          done;

    modport master (
        output load, din, mode, dtype, send,
        input  dout, dout_valid, busy, loaded, done
    );

    modport slave (
        input  load, din, mode, dtype, send,
        output dout, dout_valid, busy, loaded, done
    );
endinterface
`default_nettype wire

// File: rtl/simd_stream_alu.sv
`default_nettype none
// ============================================================================
// Module  : simd_stream_alu
// Purpose : Serially loads vectors A and B, applies one lane-wise operation
//           and streams the result vector out as OW-bit beats.
// Rev     : 1.0  initial release
// ============================================================================
module simd_stream_alu #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int OW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    simd_stream_alu_if.slave bus
);
    localparam int c_nb = LANES * DW / OW;
    localparam int c_pw = $clog2(2 * LANES);
    localparam int c_bw = $clog2(c_nb);
    localparam logic [c_pw-1:0] c_ptr_last  = c_pw'(2 * LANES - 1);
    localparam logic [c_bw-1:0] c_beat_last = c_bw'(c_nb - 1);
    localparam logic [DW-1:0]   c_smax      = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   c_smin      = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_READY   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_pw-1:0]       r_ptr;
    logic [DW-1:0]         r_a [LANES];
    logic [DW-1:0]         r_b [LANES];
    logic [LANES*DW-1:0]   r_res;
    logic [LANES*DW-1:0]   w_res;
    logic [c_bw-1:0]       r_beat;
    logic [3:0]            r_mode;
    logic                  r_dtype;
    logic                  r_send_q;
    logic                  r_load_block;
    logic                  r_loaded;
    logic                  r_done;
    logic                  w_send_edge;
    logic                  w_load_ok;
    logic                  w_capture;

    // Operands are extended to DW+1 bits so the difference is exact for both
    // signednesses; its top bit is then the "a < b" flag in either case.
    function automatic logic [DW-1:0] lane_op(
        input logic [3:0]    op,
        input logic          sgn,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [DW:0]   ax;
        logic [DW:0]   bx;
        logic [DW:0]   sum;
        logic [DW:0]   dif;
        logic [DW:0]   mag;
        logic [DW-1:0] res;
        ax  = sgn ? {a[DW-1], a} : {1'b0, a};
        bx  = sgn ? {b[DW-1], b} : {1'b0, b};
        sum = ax + bx;
        dif = ax - bx;
        mag = dif[DW] ? (~dif + {{DW{1'b0}}, 1'b1}) : dif;
        res = a;
        case (op)
            4'd0: res = sum[DW-1:0];
            4'd1: res = dif[DW-1:0];
            4'd2: begin
                if (sgn) res = (sum[DW] != sum[DW-1]) ? (sum[DW] ? c_smin : c_smax) : sum[DW-1:0];
                else     res = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
            end
            4'd3: begin
                if (sgn) res = (dif[DW] != dif[DW-1]) ? (dif[DW] ? c_smin : c_smax) : dif[DW-1:0];
                else     res = dif[DW] ? {DW{1'b0}} : dif[DW-1:0];
            end
            4'd4:  res = dif[DW] ? a : b;
            4'd5:  res = dif[DW] ? b : a;
            4'd6:  res = a & b;
            4'd7:  res = a | b;
            4'd8:  res = a ^ b;
            4'd9:  res = a * b;
            4'd10: res = (sgn && (mag > {1'b0, c_smax})) ? c_smax : mag[DW-1:0];
            default: res = a;
        endcase
        return res;
    endfunction

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_res[i*DW +: DW] = lane_op(r_mode, r_dtype, r_a[i], r_b[i]);
        end
    endgenerate

    assign w_send_edge = bus.send && !r_send_q;
    assign w_load_ok   = bus.load && !r_load_block;
    assign w_capture   = (w_next == ST_LOAD) || ((r_state == ST_LOAD) && (w_next == ST_READY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_load_ok) w_next = ST_LOAD;
            ST_LOAD: begin
                if (!bus.load)                w_next = ST_IDLE;
                else if (r_ptr == c_ptr_last) w_next = ST_READY;
            end
            ST_READY: begin
                if (w_load_ok)        w_next = ST_LOAD;
                else if (w_send_edge) w_next = ST_COMPUTE;
            end
            ST_COMPUTE: w_next = ST_SEND;
            ST_SEND:    if (r_beat == c_beat_last) w_next = ST_READY;
            default:    w_next = ST_IDLE;
        endcase
    end

    // The pointer is only non-zero while a load is in flight, so a fresh load
    // from IDLE or READY always lands its first element in A[0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_res        <= '0;
            r_beat       <= '0;
            r_mode       <= '0;
            r_dtype      <= 1'b0;
            r_send_q     <= 1'b0;
            r_load_block <= 1'b0;
            r_loaded     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_send_q <= bus.send;
            r_ptr    <= (w_next == ST_LOAD) ? r_ptr + c_pw'(1) : '0;
            r_done   <= (r_state == ST_SEND) && (w_next == ST_READY);

            if ((r_state != ST_LOAD) && (w_next == ST_LOAD)) begin
                r_loaded <= 1'b0;
            end else if ((r_state == ST_LOAD) && (w_next == ST_READY)) begin
                r_loaded <= 1'b1;
            end

            if ((r_state == ST_LOAD) && (w_next == ST_READY)) begin
                r_load_block <= 1'b1;
            end else if (!bus.load) begin
                r_load_block <= 1'b0;
            end

            if ((r_state == ST_READY) && (w_next == ST_COMPUTE)) begin
                r_mode  <= bus.mode;
                r_dtype <= bus.dtype;
            end

            if (r_state == ST_COMPUTE) begin
                r_res  <= w_res;
                r_beat <= '0;
            end else if (r_state == ST_SEND) begin
                r_res  <= r_res >> OW;
                r_beat <= r_beat + c_bw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_ptr == c_pw'(i))         r_a[i] <= bus.din;
                if (r_ptr == c_pw'(LANES + i)) r_b[i] <= bus.din;
            end
        end
    end

    assign bus.dout       = (r_state == ST_SEND) ? r_res[OW-1:0] : '0;
    assign bus.dout_valid = (r_state == ST_SEND);
    assign bus.busy       = (r_state == ST_COMPUTE) || (r_state == ST_SEND);
    assign bus.loaded     = r_loaded;
    assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_simd_stream_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_simd_stream_alu
// Purpose : Self-checking bench for simd_stream_alu (16 lanes, 8-bit, 4-bit beats).
// Rev     : 1.0  initial release
// ============================================================================
module tb_simd_stream_alu;
    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int OW    = 4;
    localparam int NB    = LANES * DW / OW;

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] b0;
        logic [3:0] mode;
        logic       dtype;
        logic [7:0] exp;
        logic       reload;
        logic       uniform;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nfail;
    logic [7:0] va [LANES];
    logic [7:0] vb [LANES];
    logic [OW-1:0] exp_q [$];
    vec_t tbl [27];

    simd_stream_alu_if #(.DW(DW), .OW(OW)) bus ();

    simd_stream_alu #(.LANES(LANES), .DW(DW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference written with plain integer arithmetic and clamping.
    function automatic logic [7:0] model(input logic [3:0] m, input logic s,
                                         input logic [7:0] a, input logic [7:0] b);
        int ia, ib, lo, hi, r;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        lo = s ? -128 : 0;
        hi = s ? 127 : 255;
        case (m)
            4'd0:  r = ia + ib;
            4'd1:  r = ia - ib;
            4'd2:  begin r = ia + ib; if (r > hi) r = hi; if (r < lo) r = lo; end
            4'd3:  begin r = ia - ib; if (r > hi) r = hi; if (r < lo) r = lo; end
            4'd4:  r = (ia < ib) ? ia : ib;
            4'd5:  r = (ia > ib) ? ia : ib;
            4'd6:  r = int'(a & b);
            4'd7:  r = int'(a | b);
            4'd8:  r = int'(a ^ b);
            4'd9:  r = int'(a) * int'(b);
            4'd10: begin r = (ia > ib) ? ia - ib : ib - ia; if (s && r > 127) r = 127; end
            default: r = ia;
        endcase
        return r[7:0];
    endfunction

    task automatic fill(input bit uniform, input logic [7:0] a0, input logic [7:0] b0);
        for (int l = 0; l < LANES; l++) begin
            va[l] = (uniform || l == 0) ? a0 : 8'($urandom);
            vb[l] = (uniform || l == 0) ? b0 : 8'($urandom);
        end
    endtask

    task automatic load_vec(input int n);
        for (int k = 0; k < n; k++) begin
            if (k < LANES)          bus.din = va[k];
            else if (k < 2 * LANES) bus.din = vb[k - LANES];
            else                    bus.din = 8'h5A;
            bus.load = 1'b1;
            @(posedge clk); #1;
        end
        bus.load = 1'b0;
        bus.din  = '0;
        @(posedge clk); #1;
    endtask

    task automatic push_expected(input logic [3:0] m, input logic s, input bit use_exp,
                                 input logic [7:0] e0, input bit all_exp);
        logic [7:0] r;
        for (int l = 0; l < LANES; l++) begin
            r = (use_exp && (all_exp || l == 0)) ? e0 : model(m, s, va[l], vb[l]);
            for (int k = 0; k < DW / OW; k++) exp_q.push_back(r[k*OW +: OW]);
        end
    endtask

    task automatic check_beat(input int idx);
        logic [OW-1:0] e;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_beat%0d", idx), 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d", idx), int'(bus.dout), int'(e));
        end
    endtask

    // Sends one operation and checks the whole stream, its timing and the
    // done pulse. Without hold, a stray send edge and a load pulse are
    // injected mid-stream; with hold, send stays high past completion.
    task automatic run(input logic [3:0] m, input logic s, input bit use_exp,
                       input logic [7:0] e0, input bit all_exp, input bit hold);
        int beats, busy_n, first_c, c, extra;
        bit got_done;
        push_expected(m, s, use_exp, e0, all_exp);
        bus.mode  = m;
        bus.dtype = s;
        bus.send  = 1'b1;
        @(posedge clk); #1;
        bus.send = hold;
        beats = 0; busy_n = 0; first_c = -1; c = 0; got_done = 1'b0;
        while (!got_done && c < 80) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.dout_valid) begin
                if (first_c < 0) first_c = c;
                check_beat(beats);
                beats++;
            end
            if (bus.done) begin
                got_done = 1'b1;
                chk("dout_idle_at_done", int'(bus.dout), 0);
            end
            if (!hold) begin
                if (c == 5) bus.send = 1'b1;
                if (c == 6) bus.send = 1'b0;
                if (c == 8) begin bus.load = 1'b1; bus.din = 8'hAA; end
                if (c == 9) begin bus.load = 1'b0; bus.din = '0; end
            end
            c++;
        end
        chk("done_seen", int'(got_done), 1);
        chk("beat_count", beats, NB);
        chk("first_beat_latency", first_c, 1);
        chk("busy_cycles", busy_n, NB + 1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.dout_valid) extra++;
        end
        chk("quiet_after_done", extra, 0);
        bus.send = 1'b0;
        chk("loaded_kept", int'(bus.loaded), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen, bad;
        nvec = 0;
        nfail = 0;
        rst = 1'b0;
        bus.load = 1'b0; bus.din = '0; bus.mode = '0; bus.dtype = 1'b0; bus.send = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_dout_valid", int'(bus.dout_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_loaded", int'(bus.loaded), 0);
        chk("rst_done", int'(bus.done), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = '{8'h7F, 8'h02, 4'd2,  1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[1]  = '{8'h7F, 8'h02, 4'd2,  1'b0, 8'h81, 1'b0, 1'b1};
        tbl[2]  = '{8'h7F, 8'h02, 4'd1,  1'b0, 8'h7D, 1'b0, 1'b1};
        tbl[3]  = '{8'h03, 8'h05, 4'd1,  1'b1, 8'hFE, 1'b1, 1'b0};
        tbl[4]  = '{8'h03, 8'h05, 4'd3,  1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[5]  = '{8'h03, 8'h05, 4'd4,  1'b1, 8'h03, 1'b0, 1'b0};
        tbl[6]  = '{8'h03, 8'h05, 4'd3,  1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{8'h03, 8'h05, 4'd10, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[8]  = '{8'h80, 8'h01, 4'd4,  1'b1, 8'h80, 1'b1, 1'b0};
        tbl[9]  = '{8'h80, 8'h01, 4'd4,  1'b0, 8'h01, 1'b0, 1'b0};
        tbl[10] = '{8'h80, 8'h01, 4'd3,  1'b1, 8'h80, 1'b0, 1'b0};
        tbl[11] = '{8'h80, 8'h01, 4'd5,  1'b1, 8'h01, 1'b0, 1'b0};
        tbl[12] = '{8'h13, 8'h2E, 4'd9,  1'b0, 8'h6A, 1'b1, 1'b0};
        tbl[13] = '{8'h13, 8'h2E, 4'd9,  1'b1, 8'h6A, 1'b0, 1'b0};
        tbl[14] = '{8'h7F, 8'h80, 4'd10, 1'b1, 8'h7F, 1'b1, 1'b0};
        tbl[15] = '{8'h7F, 8'h80, 4'd10, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[16] = '{8'h7F, 8'h80, 4'd2,  1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[17] = '{8'hF0, 8'h20, 4'd2,  1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[18] = '{8'hF0, 8'h10, 4'd5,  1'b1, 8'h10, 1'b1, 1'b0};
        tbl[19] = '{8'hA5, 8'h3C, 4'd8,  1'b0, 8'h99, 1'b1, 1'b0};
        tbl[20] = '{8'hA5, 8'h3C, 4'd6,  1'b1, 8'h24, 1'b0, 1'b0};
        tbl[21] = '{8'hA5, 8'h3C, 4'd7,  1'b0, 8'hBD, 1'b0, 1'b0};
        tbl[22] = '{8'hA5, 8'h3C, 4'd12, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[23] = '{8'h05, 8'h03, 4'd0,  1'b1, 8'h08, 1'b1, 1'b0};
        tbl[24] = '{8'h60, 8'h50, 4'd2,  1'b1, 8'h7F, 1'b1, 1'b0};
        tbl[25] = '{8'h90, 8'hA0, 4'd2,  1'b1, 8'h80, 1'b1, 1'b0};
        tbl[26] = '{8'h90, 8'hA0, 4'd0,  1'b0, 8'h30, 1'b0, 1'b0};

        for (int t = 0; t < 27; t++) begin
            if (tbl[t].reload) begin
                fill(tbl[t].uniform, tbl[t].a0, tbl[t].b0);
                load_vec(2 * LANES);
                chk($sformatf("loaded_after_load_t%0d", t), int'(bus.loaded), 1);
            end
            run(tbl[t].mode, tbl[t].dtype, 1'b1, tbl[t].exp, tbl[t].uniform, 1'b0);
        end

        // Load held beyond the last element, then send held high past done.
        fill(1'b0, 8'h11, 8'h22);
        load_vec(2 * LANES + 3);
        chk("loaded_overlong", int'(bus.loaded), 1);
        run(4'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Partial load followed by a send: nothing may happen.
        fill(1'b0, 8'h44, 8'h55);
        load_vec(20);
        chk("loaded_partial", int'(bus.loaded), 0);
        bus.send = 1'b1;
        @(posedge clk); #1;
        bus.send = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.dout_valid || bus.busy || bus.done) bad++;
        end
        chk("partial_no_activity", bad, 0);
        load_vec(2 * LANES);
        chk("loaded_after_reload", int'(bus.loaded), 1);
        run(4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset asserted during beat 10, send held high across its release.
        fill(1'b0, 8'h66, 8'h77);
        load_vec(2 * LANES);
        push_expected(4'd5, 1'b0, 1'b0, 8'h00, 1'b0);
        bus.mode = 4'd5; bus.dtype = 1'b0; bus.send = 1'b1;
        @(posedge clk); #1;
        bus.send = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen < 10; c++) begin
            @(negedge clk);
            if (bus.dout_valid) begin
                check_beat(seen);
                seen++;
            end
        end
        chk("beats_before_abort", seen, 10);
        rst = 1'b0;
        #1;
        chk("abort_dout_valid", int'(bus.dout_valid), 0);
        chk("abort_dout", int'(bus.dout), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_loaded", int'(bus.loaded), 0);
        exp_q.delete();
        bus.send = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.dout_valid || bus.busy || bus.done || bus.loaded) bad++;
        end
        chk("no_start_after_reset", bad, 0);
        bus.send = 1'b0;
        @(posedge clk); #1;

        fill(1'b0, 8'h9C, 8'h3A);
        load_vec(2 * LANES);
        run(4'd10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/simd_stream_alu.md
Name: simd_stream_alu

Overview:
Parametrised successor to the team's 16-lane byte SIMD unit. Serially loads two vectors A and B of LANES elements, each DW bits wide. On a send request it computes one of 12 lane-wise operations (signed or unsigned, wrapping or saturating). It then streams the result vector out as OW-bit beats with a valid flag and a completion pulse. It sits between the Pico-facing byte loader and the narrow return bus back to the host.

Parameters:
LANES, 16, number of vector elements per operand (>=2)
DW, 8, element width in bits (4..16)
OW, 4, output beat width; LANES*DW must be a multiple of OW and OW <= DW

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
load  in  1  load enable; one element captured per cycle while high
din  in  DW  element input, A[0..LANES-1] then B[0..LANES-1]
mode  in  4  operation select, sampled at send start
dtype  in  1  1 = signed two's complement, 0 = unsigned, sampled at send start
send  in  1  start compute/stream, rising-edge detected internally
dout  out  OW  result beat
dout_valid  out  1  high on every cycle dout carries a beat
busy  out  1  high in COMPUTE and SEND
loaded  out  1  both vectors fully loaded
done  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, load pointer 0, A/B/R cleared, dout=0, dout_valid=0, busy=0, loaded=0, done=0, send edge register=0. Reset mid-load or mid-stream aborts with no further beats.
- States: IDLE, LOAD, READY, COMPUTE, SEND.
- IDLE/READY with load=1: go to LOAD. Pointer is 0, loaded is cleared, and din is captured in that same cycle into A[0].
- LOAD: each cycle with load=1, din goes to A[ptr] for ptr<LANES, else B[ptr-LANES], and ptr increments.
  - After capture at ptr=2*LANES-1: loaded=1, go to READY. Further load cycles are ignored until load is low for at least one cycle.
  - load dropping early: return to IDLE with loaded=0 and pointer 0. A partial load is not usable.
- send edge: send=1 while the previous sample was 0. It is accepted only in READY; otherwise it is ignored and no edge is remembered. A send held high does not retrigger.
- COMPUTE, 1 cycle: latch mode/dtype, then R[i]=op(A[i],B[i]) for all lanes in parallel.
- SEND: NB=LANES*DW/OW beats, one per cycle, back-to-back. Beat order is lane 0 first, least-significant OW bits of each lane first. dout_valid=1 in every SEND cycle.
- First beat appears 2 cycles after the cycle the send edge is sampled.
- After the last beat: dout_valid=0 and dout=0. done=1 for exactly one cycle, then return to READY. A/B are retained, so a new mode can be run without reloading.
- load and send are ignored in COMPUTE and SEND.
- mode encoding (results DW bits):
  - 0: add, wrap
  - 1: sub A-B, wrap
  - 2: add, saturating
  - 3: sub, saturating
  - 4: min
  - 5: max
  - 6: AND
  - 7: OR
  - 8: XOR
  - 9: low DW bits of A*B
  - 10: |A-B|, saturating to max positive when signed
  - 11-15: pass A unchanged
- dtype affects modes 2, 3, 4, 5 and 10 only.
  - Signed saturation: max 2^(DW-1)-1, min -2^(DW-1).
  - Unsigned saturation: max 2^DW-1, min 0.
- Intermediate arithmetic is DW+1 bits, or 2*DW bits for mode 9.

Test Plan:
- Load A=all 0x7F, B=all 0x02, dtype=1, mode=2, send -> 32 beats; each lane is 0x7F, so the beats are F,7,F,7...; done pulses after beat 32; busy spans 33 cycles.
- Same data, dtype=0, mode=2 -> lane 0x81, beats 1,8 repeated; then mode=1 without reload -> 0x7D, beats D,7.
- A[0]=0x03, B[0]=0x05, dtype=1: mode 1 -> 0xFE, mode 3 -> 0xFE, mode 4 -> 0x03; dtype=0 mode 3 -> 0x00, mode 10 -> 0x02.
- A[0]=0x80, B[0]=0x01, dtype=1 mode 4 -> 0x80; dtype=0 mode 4 -> 0x01; mode 9 with A[0]=0x13, B[0]=0x2E -> 0x6A.
- load dropped after 20 elements, then send -> no beats, loaded=0, state IDLE. A full reload followed by send produces a correct stream.
- rst pulsed low during beat 10 -> dout_valid falls immediately, loaded=0, and no done pulse. Holding send high across reset release starts nothing.
